// File: rtl/tnt_ram_writer_pkg.sv
// Shared constants for the TNT RAM writer: host command codes and FSM states.
package tnt_ram_writer_pkg;

    // Host command codes carried on uio_in[2:1]
    localparam logic [1:0] CMD_SET_ADDR = 2'b00;
    localparam logic [1:0] CMD_WRITE    = 2'b01;
    localparam logic [1:0] CMD_READ     = 2'b10;
    localparam logic [1:0] CMD_CHECKSUM = 2'b11;

    // Handshake FSM: wait for strobe, execute one command, hold ack until strobe drops
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StHold = 2'b10
    } state_e;

endpackage

// File: rtl/tnt_strobe_sync.sv
// Two-flop synchronizer for the asynchronous host strobe, plus a rising-edge detector.
module tnt_strobe_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= strobe_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/tt_um_tnt_ram_writer.sv
// Byte-wide register-file RAM driven by a strobe/ack host handshake.
// Optional feature: define RAM_CHECKSUM_EN to add an XOR accumulator over every
// WRITE since reset, readable with the CHECKSUM command.
module tt_um_tnt_ram_writer
    import tnt_ram_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [7:0]        mem_q [Depth];
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_inc;
    logic [7:0]        data_q;
    logic              ack_q;
    state_e            state_q;

    logic              strobe_level;
    logic              strobe_rise;
    logic [1:0]        cmd;
    logic              mem_we;
    logic              unused_uio;

`ifdef RAM_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign cmd        = uio_in[2:1];
    assign unused_uio = ^uio_in[7:3];
    // Increment wraps naturally at the pointer width
    assign ptr_inc    = ptr_q + ADDR_W'(1);
    assign mem_we     = (state_q == StExec) && (cmd == CMD_WRITE);

    tnt_strobe_sync u_strobe_sync (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .strobe_i (uio_in[0]),
        .level_o  (strobe_level),
        .rise_o   (strobe_rise)
    );

    // RAM array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= ui_in;
        end
    end

    // Handshake FSM with pointer, read-data and ack registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            data_q  <= 8'h00;
            ack_q   <= 1'b0;
`ifdef RAM_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // ena only gates the start of a transaction
                    if (ena && strobe_rise) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    ack_q   <= 1'b1;
                    state_q <= StHold;
                    unique case (cmd)
                        CMD_SET_ADDR: ptr_q <= ui_in[ADDR_W-1:0];
                        CMD_WRITE: begin
                            ptr_q  <= ptr_inc;
`ifdef RAM_CHECKSUM_EN
                            csum_q <= csum_q ^ ui_in;
`endif
                        end
                        CMD_READ: begin
                            data_q <= mem_q[ptr_q];
                            ptr_q  <= ptr_inc;
                        end
                        CMD_CHECKSUM: begin
`ifdef RAM_CHECKSUM_EN
                            data_q <= csum_q;
`endif
                        end
                        default: ;
                    endcase
                end
                StHold: begin
                    // A strobe held high stays here, so it executes only once
                    if (!strobe_level) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = data_q;
    assign uio_out = {ack_q, 7'b0};
    assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_tnt_ram_writer.sv
// Self-checking bench for tt_um_tnt_ram_writer: directed scenarios plus random
// commands checked against a behavioural RAM/pointer model.
module tb_tt_um_tnt_ram_writer;
    import tnt_ram_writer_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_tnt_ram_writer #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] ref_mem [DEPTH];
    int         ref_ptr  = 0;
    logic [7:0] ref_uo   = 8'h00;
    logic [7:0] ref_csum = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_exec(input logic [1:0] cmd, input logic [7:0] op);
        case (cmd)
            2'd0: ref_ptr = op % DEPTH;
            2'd1: begin
                ref_mem[ref_ptr] = op;
                ref_csum = ref_csum ^ op;
                ref_ptr = (ref_ptr + 1) % DEPTH;
            end
            2'd2: begin
                ref_uo = ref_mem[ref_ptr];
                ref_ptr = (ref_ptr + 1) % DEPTH;
            end
            default: begin
`ifdef RAM_CHECKSUM_EN
                ref_uo = ref_csum;
`endif
            end
        endcase
    endtask

    // Full handshake: checks ack latency, result, and ack release timing
    task automatic send(input string tag, input logic [1:0] cmd, input logic [7:0] op,
                        input int hold, input bit drop_ena);
        int first;
        @(negedge clk);
        ui_in  = op;
        uio_in = {5'b0, cmd, 1'b1};
        first  = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[7]) first = i;
        end
        check({tag, "_ack_rise"}, 8'(first), 8'd3);
        model_exec(cmd, op);
        check({tag, "_data"}, uo_out, ref_uo);
        if (drop_ena) ena = 1'b0;
        repeat (hold) @(posedge clk);
        #2;
        uio_in[0] = 1'b0;
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            @(posedge clk);
            #1;
            if (!uio_out[7]) first = i;
        end
        check({tag, "_ack_fall"}, 8'(first), 8'd2);
        check({tag, "_oe"}, uio_oe, 8'h80);
        check({tag, "_uio_low"}, {1'b0, uio_out[6:0]}, 8'h00);
        ena    = 1'b1;
        uio_in = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_uo", uo_out, 8'h00);
        check("reset_ack", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ref_ptr  = 0;
        ref_uo   = 8'h00;
        ref_csum = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [7:0] saved;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("por_uo", uo_out, 8'h00);
        check("por_uio_out", uio_out, 8'h00);
        check("por_oe", uio_oe, 8'h80);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill RAM with known random data
        send("fill_set", CMD_SET_ADDR, 8'h00, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send("fill_wr", CMD_WRITE, 8'($urandom), 0, 1'b0);
        end

        // ena low: strobe ignored, pointer unchanged
        send("ena_set", CMD_SET_ADDR, 8'h07, 0, 1'b0);
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'h99;
        uio_in = {5'b0, CMD_WRITE, 1'b1};
        first  = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[7] && first < 0) first = i;
        end
        uio_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("ena_off_ack", 8'(first), 8'hFF);
        ena = 1'b1;
        send("ena_off_read", CMD_READ, 8'h00, 0, 1'b0);

        // Basic write then read back
        send("b_set", CMD_SET_ADDR, 8'h05, 0, 1'b0);
        send("b_wr", CMD_WRITE, 8'hA5, 0, 1'b0);
        send("b_set2", CMD_SET_ADDR, 8'h05, 0, 1'b0);
        send("b_rd", CMD_READ, 8'h00, 0, 1'b0);
        check("b_rd_const", uo_out, 8'hA5);

        // Pointer wrap at top of memory
        send("w_set", CMD_SET_ADDR, 8'h3F, 0, 1'b0);
        send("w_wr1", CMD_WRITE, 8'h11, 0, 1'b0);
        send("w_wr2", CMD_WRITE, 8'h22, 0, 1'b0);
        send("w_set0", CMD_SET_ADDR, 8'h00, 0, 1'b0);
        send("w_rd", CMD_READ, 8'h00, 0, 1'b0);
        check("w_rd_const", uo_out, 8'h22);

        // Held strobe executes exactly one write
        send("h_set", CMD_SET_ADDR, 8'h11, 0, 1'b0);
        send("h_wr", CMD_WRITE, 8'h5A, 0, 1'b0);
        send("h_set2", CMD_SET_ADDR, 8'h10, 0, 1'b0);
        send("h_held", CMD_WRITE, 8'h77, 17, 1'b0);
        send("h_rd_next", CMD_READ, 8'h00, 0, 1'b0);
        check("h_rd_next_const", uo_out, 8'h5A);
        send("h_set3", CMD_SET_ADDR, 8'h10, 0, 1'b0);
        send("h_rd", CMD_READ, 8'h00, 0, 1'b0);
        check("h_rd_const", uo_out, 8'h77);

        // Checksum after a fresh reset
        pulse_reset();
        send("c_wr1", CMD_WRITE, 8'h0F, 0, 1'b0);
        send("c_wr2", CMD_WRITE, 8'hF0, 0, 1'b0);
        send("c_wr3", CMD_WRITE, 8'h33, 0, 1'b0);
        send("c_set", CMD_SET_ADDR, 8'h01, 0, 1'b0);
        send("c_rd", CMD_READ, 8'h00, 0, 1'b0);
        send("c_sum", CMD_CHECKSUM, 8'h00, 0, 1'b0);
`ifdef RAM_CHECKSUM_EN
        check("c_sum_const", uo_out, 8'hCC);
`else
        check("c_sum_const", uo_out, 8'hF0);
`endif

        // Random traffic, including ena dropped during the hold phase
        for (int n = 0; n < 40; n++) begin
            send("rnd", 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
        end

        // Reset during HOLD after a READ
        send("r_set", CMD_SET_ADDR, 8'h09, 0, 1'b0);
        saved = ref_mem[0];
        @(negedge clk);
        ui_in  = 8'h00;
        uio_in = {5'b0, CMD_READ, 1'b1};
        first  = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[7]) first = i;
        end
        check("r_ack_rise", 8'(first), 8'd3);
        model_exec(CMD_READ, 8'h00);
        check("r_rd", uo_out, ref_uo);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_uo_zero", uo_out, 8'h00);
        check("r_ack_zero", uio_out, 8'h00);
        ref_ptr  = 0;
        ref_uo   = 8'h00;
        ref_csum = 8'h00;
        @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("r_no_spurious_ack", uio_out, 8'h00);
        send("r_after", CMD_READ, 8'h00, 0, 1'b0);
        check("r_after_mem0", uo_out, saved);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_tnt_ram_writer.md
TT_UM_TNT_RAM_WRITER -- requirements
Module: tt_um_tnt_ram_writer

Interface
REQ-001 Parameter: ADDR_W, default 6, memory address width; depth = 2**ADDR_W bytes.
REQ-002 clk  input  1  single clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  design enable; strobes ignored while low.
REQ-005 ui_in  input  8  command operand: address (low ADDR_W bits) or write data.
REQ-006 uio_in  input  8  [0] strobe (asynchronous to clk), [2:1] command code, [7:3] unused.
REQ-007 uo_out  output  8  read-data / checksum register.
REQ-008 uio_out  output  8  [7] ack, [6:0] constant 0.
REQ-009 uio_oe  output  8  constant 8'h80; only bit 7 driven.

Function
REQ-010 Block SHALL contain a 2**ADDR_W x 8 register-file RAM, one address pointer (ADDR_W bits), and a 3-state FSM: IDLE, EXEC, HOLD.
REQ-011 Strobe SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized strobe with ena=1 in IDLE moves FSM to EXEC.
REQ-012 Latency: strobe high at edge N -> command takes effect at edge N+3; ack rises at the same edge.
REQ-013 Commands, sampled in EXEC: 00 SET_ADDR (ptr <= ui_in[ADDR_W-1:0]); 01 WRITE (mem[ptr] <= ui_in, ptr++); 10 READ (uo_out <= mem[ptr], ptr++); 11 CHECKSUM (see REQ-021).
REQ-014 ui_in and uio_in[2:1] SHALL be held stable by the host while strobe is high; they are not synchronized.
REQ-015 EXEC -> HOLD after one cycle; HOLD keeps ack=1 until the synchronized strobe is low, then HOLD -> IDLE with ack=0 at that edge.
REQ-016 A strobe held high SHALL execute exactly one command; a new command requires strobe low then high.
REQ-017 Pointer SHALL wrap from 2**ADDR_W-1 to 0 on WRITE/READ increment.
REQ-018 uo_out SHALL change only on READ or CHECKSUM execution; otherwise holds its value.
REQ-019 ena low during HOLD SHALL NOT abort the handshake; ena only gates IDLE -> EXEC.

Reset
REQ-020 rst_n low SHALL immediately force: FSM IDLE, synchronizer flops 0, ptr 0, uo_out 0, ack 0, checksum 0; RAM contents not reset; command in flight is dropped.

Configuration
REQ-021 With RAM_CHECKSUM_EN defined: an 8-bit register SHALL XOR-accumulate every byte written by WRITE since reset, and CHECKSUM loads it into uo_out (accumulator unchanged).
REQ-022 Without RAM_CHECKSUM_EN: no accumulator exists; CHECKSUM SHALL be a no-op except for the normal ack handshake.

Structure
REQ-023 Package tnt_ram_writer_pkg SHALL hold command-code constants (CMD_SET_ADDR, CMD_WRITE, CMD_READ, CMD_CHECKSUM) and FSM state encodings.
REQ-024 Synchronizer plus rising-edge detector SHALL be one sub-module, tnt_strobe_sync.

Verification
REQ-025 Reset, then SET_ADDR 0x05, WRITE 0xA5, SET_ADDR 0x05, READ -> uo_out=0xA5, ack rises 3 edges after each strobe.
REQ-026 SET_ADDR 0x3F, WRITE 0x11, WRITE 0x22, SET_ADDR 0x00, READ -> uo_out=0x22 (wrap to 0).
REQ-027 Strobe held high 20 cycles with WRITE 0x77 at ptr 0x10 -> one write only, ptr=0x11, ack high until 2 edges after strobe falls.
REQ-028 RAM_CHECKSUM_EN: WRITE 0x0F, 0xF0, 0x33 then CHECKSUM -> uo_out=0xCC; without macro -> uo_out unchanged, ack still pulses.
REQ-029 rst_n low during HOLD after READ -> uo_out=0, ack=0, ptr=0 immediately; a subsequent strobe executes normally.
REQ-030 ena=0 with strobe pulse -> no execution, ack stays 0, ptr unchanged.
